seg_scan_controller: RTL

- Time-multiplexes the Basys3 4-digit seven-segment display from a single prescaled scan tick.
- Owns its own prescaler and sequences anode and segment drive with a dead-time guard between digits.
- Takes display updates through a latched, frame-aligned handshake, so a frame never mixes old and new values.
- Sits between the calculator stack/ALU result path and the board pins.

---
 rtl/seg_scan_controller_if.sv | 21 ++
 rtl/seg_scan_controller.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_controller_if.sv
// Display-update bus between the result path and the seven-segment scan controller.
interface seg_scan_controller_if #(
  parameter int unsigned DIGITS = 4
);
  logic [4*DIGITS-1:0] DIGIT_DATA;
  logic [DIGITS-1:0]   DIGIT_EN;
  logic [DIGITS-1:0]   DP_IN;
  logic                UPDATE;
  logic                PENDING;
  logic                UPDATE_ACK;

  modport master (
    output DIGIT_DATA, DIGIT_EN, DP_IN, UPDATE,
    input  PENDING, UPDATE_ACK
  );

  modport slave (
    input  DIGIT_DATA, DIGIT_EN, DP_IN, UPDATE,
    output PENDING, UPDATE_ACK
  );
endinterface

// File: rtl/seg_scan_controller.sv
// Time-multiplexed seven-segment scanner with per-digit dead time and
// frame-aligned latching of display updates.
module seg_scan_controller #(
  parameter int unsigned IN_FREQ      = 100_000_000,
  parameter int unsigned SCAN_FREQ    = 1000,
  parameter int unsigned GUARD_CYCLES = 4,
  parameter int unsigned DIGITS       = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  seg_scan_controller_if.slave bus,
  output logic [DIGITS-1:0] AN,
  output logic [6:0]        SEG,
  output logic              DP
);

  localparam int unsigned TICK_COUNT = IN_FREQ / SCAN_FREQ;
  localparam int unsigned CNT_W      = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
  localparam int unsigned GRD_W      = $clog2(GUARD_CYCLES + 1);
  localparam int unsigned IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DATA_W     = 4 * DIGITS;

  typedef enum logic [1:0] {S_IDLE, S_GUARD, S_DRIVE} state_t;

  state_t             state_q, state_nx;
  logic [IDX_W-1:0]   idx_q, idx_nx;
  logic [GRD_W-1:0]   grd_q, grd_nx;
  logic [CNT_W-1:0]   cnt_q;
  logic               tick_c;
  logic               boundary_c;

  logic [DATA_W-1:0]  act_data_q, pend_data_q;
  logic [DIGITS-1:0]  act_en_q, pend_en_q;
  logic [DIGITS-1:0]  act_dp_q, pend_dp_q;
  logic               pending_q;
  logic               ack_q;

  logic [DIGITS-1:0]  an_c;
  logic [6:0]         seg_c;
  logic               dp_c;
  logic [3:0]         nib_c;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Free-running scan prescaler
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_W'(TICK_COUNT - 1)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tick_c = (cnt_q == CNT_W'(TICK_COUNT - 1));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      grd_q   <= '0;
    end else begin
      state_q <= state_nx;
      idx_q   <= idx_nx;
      grd_q   <= grd_nx;
    end
  end

  always_comb begin
    state_nx   = state_q;
    idx_nx     = idx_q;
    grd_nx     = grd_q;
    boundary_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tick_c) begin
          state_nx   = S_GUARD;
          idx_nx     = '0;
          grd_nx     = '0;
          boundary_c = 1'b1;
        end
      end
      S_GUARD: begin
        if (grd_q == GRD_W'(GUARD_CYCLES - 1)) begin
          state_nx = S_DRIVE;
        end else begin
          grd_nx = grd_q + GRD_W'(1);
        end
      end
      S_DRIVE: begin
        if (tick_c) begin
          state_nx = S_GUARD;
          grd_nx   = '0;
          if (idx_q == IDX_W'(DIGITS - 1)) begin
            idx_nx     = '0;
            boundary_c = 1'b1;
          end else begin
            idx_nx = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_nx = S_IDLE;
        idx_nx   = '0;
        grd_nx   = '0;
      end
    endcase
  end

  // Pin drive derived from the current state; registered below
  always_comb begin
    an_c  = '1;
    seg_c = 7'h7F;
    dp_c  = 1'b1;
    nib_c = act_data_q[4*int'(idx_q) +: 4];
    if (state_q != S_IDLE) begin
      seg_c = hex_to_seg(nib_c);
      dp_c  = ~act_dp_q[idx_q];
    end
    if (state_q == S_DRIVE && act_en_q[idx_q]) begin
      an_c[idx_q] = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      AN  <= '1;
      SEG <= 7'h7F;
      DP  <= 1'b1;
    end else begin
      AN  <= an_c;
      SEG <= seg_c;
      DP  <= dp_c;
    end
  end

  // Update handshake: a strobe coinciding with the boundary bypasses pending
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      act_data_q  <= '0;
      act_en_q    <= '0;
      act_dp_q    <= '0;
      pend_data_q <= '0;
      pend_en_q   <= '0;
      pend_dp_q   <= '0;
      pending_q   <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      if (boundary_c && bus.UPDATE) begin
        act_data_q <= bus.DIGIT_DATA;
        act_en_q   <= bus.DIGIT_EN;
        act_dp_q   <= bus.DP_IN;
        pending_q  <= 1'b0;
        ack_q      <= 1'b1;
      end else if (boundary_c && pending_q) begin
        act_data_q <= pend_data_q;
        act_en_q   <= pend_en_q;
        act_dp_q   <= pend_dp_q;
        pending_q  <= 1'b0;
        ack_q      <= 1'b1;
      end else if (bus.UPDATE) begin
        pend_data_q <= bus.DIGIT_DATA;
        pend_en_q   <= bus.DIGIT_EN;
        pend_dp_q   <= bus.DP_IN;
        pending_q   <= 1'b1;
      end
    end
  end

  assign bus.PENDING    = pending_q;
  assign bus.UPDATE_ACK = ack_q;

endmodule
